// File: rtl/ppmn_demod.sv
// Purpose : parametrised M-ary PPM demodulator (slot search, preamble check, length field, payload).
// Latency : each symbol decision is registered at the edge sampling its last chip; outputs valid next cycle.
// Backpr. : none; the chip stream is consumed at one sample per clk, symbols >= S*CHIP_BITS cycles apart.
//
// Ports   : clk/resetn (async active-low); din chip sample; rx_start arms search from IDLE;
//           corr_threshold_ext minimum slot energy; packet_detected level; dout_valid/dout/dout_erasure
//           payload symbol strobe; rx_error one-cycle abort pulse after sync.
// Option  : define PPMN_DEMOD_DEBUG_EN to add registered dbg_* copies of internal state.
module ppmn_demod #(
   parameter int SYM_BITS  = 4,
   parameter int CHIP_BITS = 2,
   parameter int SYNC_LEN  = 4,
   parameter int LEN_BITS  = 8,
   localparam int EW       = $clog2(CHIP_BITS + 1)
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                din,
   input  logic                rx_start,
   input  logic [EW-1:0]       corr_threshold_ext,
   output logic                packet_detected,
   output logic                dout_valid,
   output logic [SYM_BITS-1:0] dout,
   output logic                dout_erasure,
   output logic                rx_error
`ifdef PPMN_DEMOD_DEBUG_EN
   ,
   output logic [2:0]          dbg_state,
   output logic [SYM_BITS-1:0] dbg_slot_count,
   output logic [LEN_BITS-1:0] dbg_symbol_count,
   output logic [EW-1:0]       dbg_peak_energy,
   output logic [LEN_BITS-1:0] dbg_len
`endif
);

   localparam int S  = 1 << SYM_BITS;
   localparam int L  = LEN_BITS / SYM_BITS;
   localparam int CW = (CHIP_BITS > 1) ? $clog2(CHIP_BITS) : 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SEARCH = 3'd1,
      ST_SYNC   = 3'd2,
      ST_LEN    = 3'd3,
      ST_DATA   = 3'd4
   } state_t;

   state_t              state, state_nx;
   logic [CW-1:0]       chip_cnt;
   logic [SYM_BITS-1:0] slot_cnt, peak_slot, dec_slot;
   logic [LEN_BITS-1:0] sym_cnt, len_q, len_nx;
   logic [EW-1:0]       slot_acc, slot_e, peak_e, dec_e, win_e, thr_eff;
   logic [CHIP_BITS-1:0] win_q, win_next;
   logic                last_chip, last_slot, active, sym_dec, win_hit;
   logic                dec_eras, sync_ok, vld_nx, err_nx, pd_nx;

   // Search window: the last CHIP_BITS samples seen while searching, newest in bit 0.
   assign win_next  = (win_q << 1) | CHIP_BITS'(din);
   assign win_e     = EW'($countones(win_next));
   // A zero threshold would let an empty window lock on, so search needs at least one hit.
   assign thr_eff   = (corr_threshold_ext == '0) ? EW'(1) : corr_threshold_ext;
   assign win_hit   = (state == ST_SEARCH) && (win_e >= thr_eff);

   assign active    = (state == ST_SYNC) || (state == ST_LEN) || (state == ST_DATA);
   assign slot_e    = slot_acc + EW'(din);
   assign last_chip = (chip_cnt == CW'(CHIP_BITS - 1));
   assign last_slot = (slot_cnt == SYM_BITS'(S - 1));
   assign sym_dec   = active && last_chip && last_slot;

   // Final slot only wins on strictly greater energy, so ties keep the lowest index.
   assign dec_slot  = (slot_e > peak_e) ? slot_cnt : peak_slot;
   assign dec_e     = (slot_e > peak_e) ? slot_e : peak_e;
   assign dec_eras  = (dec_e < corr_threshold_ext);
   assign sync_ok   = (dec_slot == '0) && !dec_eras;
   assign len_nx    = (len_q << SYM_BITS) | LEN_BITS'(dec_slot);

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (rx_start) state_nx = ST_SEARCH;
         ST_SEARCH: if (win_hit)  state_nx = ST_SYNC;
         ST_SYNC: begin
            // Preamble symbol 0 is only partially observed, so its decision is not checked.
            if (sym_dec && (sym_cnt != '0)) begin
               if (!sync_ok)                                 state_nx = ST_SEARCH;
               else if (sym_cnt == LEN_BITS'(SYNC_LEN - 1))  state_nx = ST_LEN;
            end
         end
         ST_LEN: begin
            if (sym_dec) begin
               if (dec_eras)                           state_nx = ST_IDLE;
               else if (sym_cnt == LEN_BITS'(L - 1))   state_nx = (len_nx == '0) ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: if (sym_dec && (sym_cnt == len_q - LEN_BITS'(1))) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Output logic (registered below)
   always_comb begin
      vld_nx = (state == ST_DATA) && sym_dec;
      err_nx = (state == ST_LEN) && sym_dec && dec_eras;
      pd_nx  = (state_nx == ST_LEN) || (state_nx == ST_DATA);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         packet_detected <= 1'b0;
         dout_valid      <= 1'b0;
         dout            <= '0;
         dout_erasure    <= 1'b0;
         rx_error        <= 1'b0;
      end else begin
         packet_detected <= pd_nx;
         dout_valid      <= vld_nx;
         rx_error        <= err_nx;
         if (vld_nx) begin
            dout         <= dec_slot;
            dout_erasure <= dec_eras;
         end
      end
   end

   // Chip/slot/symbol counters and per-symbol peak tracking
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         win_q     <= '0;
         chip_cnt  <= '0;
         slot_cnt  <= '0;
         slot_acc  <= '0;
         sym_cnt   <= '0;
         len_q     <= '0;
         peak_e    <= '0;
         peak_slot <= '0;
      end else begin
         win_q <= (state == ST_SEARCH) ? win_next : '0;
         if (win_hit) begin
            // The hit sample closes slot 0 of preamble symbol 0.
            chip_cnt  <= '0;
            slot_cnt  <= SYM_BITS'(1);
            slot_acc  <= '0;
            sym_cnt   <= '0;
            len_q     <= '0;
            peak_e    <= win_e;
            peak_slot <= '0;
         end else if (active) begin
            if (last_chip) begin
               chip_cnt <= '0;
               slot_acc <= '0;
               slot_cnt <= slot_cnt + SYM_BITS'(1);
               if ((slot_cnt == '0) || (slot_e > peak_e)) begin
                  peak_e    <= slot_e;
                  peak_slot <= slot_cnt;
               end
            end else begin
               chip_cnt <= chip_cnt + CW'(1);
               slot_acc <= slot_e;
            end
            if (sym_dec) begin
               sym_cnt <= (state_nx != state) ? '0 : sym_cnt + LEN_BITS'(1);
               if (state == ST_LEN) len_q <= len_nx;
            end
         end else begin
            chip_cnt <= '0;
            slot_cnt <= '0;
            slot_acc <= '0;
            sym_cnt  <= '0;
         end
      end
   end

`ifdef PPMN_DEMOD_DEBUG_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dbg_state        <= '0;
         dbg_slot_count   <= '0;
         dbg_symbol_count <= '0;
         dbg_peak_energy  <= '0;
         dbg_len          <= '0;
      end else begin
         dbg_state        <= state;
         dbg_slot_count   <= slot_cnt;
         dbg_symbol_count <= sym_cnt;
         dbg_peak_energy  <= peak_e;
         dbg_len          <= len_q;
      end
   end
`endif

endmodule

// File: doc/ppmn_demod.md
# ppmn_demod

Parametrised M-ary PPM demodulator; successor to the fixed 16-PPM demodulator. Sits between the SPAD sample front-end and the packet sink. Consumes one oversampled chip per clock, acquires slot alignment and verifies a sync preamble. It then reads a length field and emits payload symbols with per-symbol erasure flags. PPM order, oversampling, preamble length and length-field width are all parameters.

## Interface
- SYM_BITS, 4: bits per symbol; slots per symbol S = 2^SYM_BITS.
- CHIP_BITS, 2: samples per slot, ≥1.
- SYNC_LEN, 4: preamble length in symbols, ≥2.
- LEN_BITS, 8: length-field width in bits; must be a multiple of SYM_BITS. L = LEN_BITS/SYM_BITS symbols.
- EW: derived, $clog2(CHIP_BITS+1).
- clk  in  1  sample clock; one chip per rising edge.
- resetn  in  1  asynchronous, active-low reset.
- din  in  1  detector chip sample.
- rx_start  in  1  one-cycle pulse; arms the search from IDLE.
- corr_threshold_ext  in  EW  minimum slot energy for a valid pulse.
- packet_detected  out  1  level; high from sync verified until the packet ends.
- dout_valid  out  1  one-cycle strobe per payload symbol.
- dout  out  SYM_BITS  demodulated payload symbol.
- dout_erasure  out  1  qualifies dout; peak energy was below threshold.
- rx_error  out  1  one-cycle pulse when a packet aborts after sync.

## Operation
- States: IDLE, SEARCH, SYNC, LEN, DATA.
- IDLE: inputs are ignored. rx_start moves the block to SEARCH. rx_start in any other state is ignored.
- Slot energy is the popcount of the slot's CHIP_BITS samples.
- SEARCH: keep a sliding window of the last CHIP_BITS samples. When the window popcount ≥ max(threshold,1), alignment is fixed: that sample is the last chip of slot 0 of preamble symbol 0. The slot counter restarts at slot 1 and the block enters SYNC.
- Symbol decision: the decided slot is the one with maximum energy; ties go to the lowest index. The symbol is an erasure if peak energy < threshold.
- SYNC: the remaining SYNC_LEN−1 symbols must each decide 0 with no erasure.
  - Any failure returns to SEARCH silently; no rx_error.
  - Success sets packet_detected and enters LEN.
- LEN: L symbols, MSB symbol first, are assembled into len[LEN_BITS−1:0].
  - Any erasure in LEN causes rx_error, clears packet_detected and returns to IDLE.
  - If len == 0, the block returns to IDLE and clears packet_detected with no data strobe.
  - Otherwise it enters DATA.
- DATA: each of len symbols produces dout_valid, dout and dout_erasure. Erasures do not abort. After the last symbol, packet_detected clears and the block returns to IDLE.
- Counters: chip counter modulo CHIP_BITS; slot counter modulo S; symbol counter width LEN_BITS. No wrap occurs beyond len.

## Timing
- Reset values: all outputs 0, state IDLE, all counters and len 0. Reset mid-packet aborts immediately with no rx_error.
- The decision is combinational on the final chip of the symbol and is registered at that edge. dout_valid and dout are high for the cycle following the edge that samples the symbol's last chip.
- packet_detected rises at the same edge as the final preamble decision.
- packet_detected falls at the edge that registers the last data strobe. For len == 0, it falls at the edge registering the final LEN decision.
- rx_error pulses at the same edge packet_detected falls on a LEN abort.
- No back-pressure exists. Symbols are at least S·CHIP_BITS cycles apart.

## Configuration
- PPMN_DEMOD_DEBUG_EN defined: adds ports dbg_state (3b), dbg_slot_count (SYM_BITS), dbg_symbol_count (LEN_BITS), dbg_peak_energy (EW) and dbg_len (LEN_BITS). All are registered copies of internal state and reset to 0.
- PPMN_DEMOD_DEBUG_EN undefined: these ports are absent. Functional behaviour is identical.

## Test plan
All scenarios use default parameters and threshold 2.
- Clean packet: 4 preamble symbols (slot 0 = "11"), len = 0x03 (symbols 0,3), data 5,A,F -> packet_detected rises after the 4th preamble symbol; three strobes 5,A,F with erasure 0; packet_detected falls with the F strobe.
- Sync failure: preamble symbol 2 is in slot 7 -> back to SEARCH; no packet_detected, no rx_error. A following valid packet is then received correctly.
- Erasure handling: data symbol 2 has peak energy 1 ("10") -> strobe with dout_erasure = 1; dout is that slot index; the packet completes.
- LEN erasure: the first LEN symbol has no pulse -> rx_error pulses once, packet_detected clears, state is IDLE; later din activity without rx_start produces no output.
- Tie and zero-length: a data symbol has "11" in slots 3 and 9 -> dout = 3. A packet with len = 0 -> no dout_valid; packet_detected clears at the LEN decision.
- Async reset asserted mid-DATA -> all outputs are 0 immediately and no strobes follow until rx_start and a new preamble.
